micro_issue: RTL and testbench

MICRO_ISSUE -- requirements
Module: micro_issue

---
 rtl/micro_issue_pkg.sv | 37 +++
 rtl/issue_scoreboard.sv | 71 +++++++
 rtl/micro_issue.sv | 104 ++++++++++
 tb/tb_micro_issue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/micro_issue_pkg.sv
// rtl/micro_issue_pkg.sv - shared micro-op widths, opcodes and issue-slot type
package micro_issue_pkg;

  localparam int MICRO_W    = 6;
  localparam int REG_ADDR_W = 4;
  localparam int IMM_W      = 16;
  localparam int BIT_MODE_W = 2;
  localparam int ADDR_W     = 32;
  localparam int NREGS      = 2 ** REG_ADDR_W;

  localparam logic [MICRO_W-1:0] MICRO_NOP = 6'd0;
  localparam logic [MICRO_W-1:0] MICRO_ADD = 6'd1;
  localparam logic [MICRO_W-1:0] MICRO_SUB = 6'd2;
  localparam logic [MICRO_W-1:0] MICRO_MOV = 6'd3;
  localparam logic [MICRO_W-1:0] MICRO_CMP = 6'd4;
  localparam logic [MICRO_W-1:0] MICRO_JCC = 6'd5;
  localparam logic [MICRO_W-1:0] MICRO_ST  = 6'd6;

  typedef struct packed {
    logic [MICRO_W-1:0]    opcode;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [IMM_W-1:0]      imm;
    logic [BIT_MODE_W-1:0] bit_mode;
    logic                  efl_mode;
    logic [ADDR_W-1:0]     pc;
  } issue_slot_t;

  localparam issue_slot_t SLOT_RST = '{opcode: MICRO_NOP, default: '0};

  // Only ALU-style ops produce a destination register; compares, branches and stores do not.
  function automatic logic writes_d(input logic [MICRO_W-1:0] op);
    return (op == MICRO_ADD) || (op == MICRO_SUB) || (op == MICRO_MOV);
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - register/EFLAGS busy tracking and in-flight credit count
module issue_scoreboard
  import micro_issue_pkg::*;
#(
  parameter int INFLIGHT_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush_i,
  input  logic                  iss_fire_i,
  input  logic                  iss_writes_d_i,
  input  logic                  iss_efl_i,
  input  logic [REG_ADDR_W-1:0] iss_rd_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_reg_addr_i,
  input  logic                  wb_writes_d_i,
  input  logic                  wb_efl_i,
  output logic [NREGS-1:0]      busy_o,
  output logic                  efl_busy_o,
  output logic                  credit_ok_o
);

  localparam int CNT_W = $clog2(INFLIGHT_MAX + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(INFLIGHT_MAX);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             efl_busy_q, efl_busy_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             wb_eff;

  // A writeback with nothing outstanding is spurious and must not underflow the count.
  assign wb_eff = wb_valid_i & (inflight_q != '0);

  always_comb begin
    busy_d     = busy_q;
    efl_busy_d = efl_busy_q;
    inflight_d = inflight_q;
    if (wb_eff) begin
      if (wb_writes_d_i) busy_d[wb_reg_addr_i] = 1'b0;
      if (wb_efl_i)      efl_busy_d = 1'b0;
    end
    if (iss_fire_i) begin
      if (iss_writes_d_i) busy_d[iss_rd_i] = 1'b1;
      if (iss_efl_i)      efl_busy_d = 1'b1;
    end
    if (iss_fire_i && !wb_eff)      inflight_d = inflight_q + CNT_W'(1);
    else if (!iss_fire_i && wb_eff) inflight_d = inflight_q - CNT_W'(1);
    if (flush_i) begin
      busy_d     = '0;
      efl_busy_d = 1'b0;
      inflight_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_q     <= '0;
      efl_busy_q <= 1'b0;
      inflight_q <= '0;
    end else begin
      busy_q     <= busy_d;
      efl_busy_q <= efl_busy_d;
      inflight_q <= inflight_d;
    end
  end

  assign busy_o      = busy_q;
  assign efl_busy_o  = efl_busy_q;
  assign credit_ok_o = (inflight_q < MAX_CNT);

endmodule

// File: rtl/micro_issue.sv
// rtl/micro_issue.sv - in-order issue stage: hazard check, stall and registered issue slot
module micro_issue
  import micro_issue_pkg::*;
#(
  parameter int INFLIGHT_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [MICRO_W-1:0]    deq_opcode_head,
  input  logic [REG_ADDR_W-1:0] deq_reg_addr_d_head,
  input  logic [REG_ADDR_W-1:0] deq_reg_addr_s_head,
  input  logic [REG_ADDR_W-1:0] deq_reg_addr_t_head,
  input  logic [IMM_W-1:0]      deq_immediate_head,
  input  logic [BIT_MODE_W-1:0] deq_bit_mode_head,
  input  logic                  deq_efl_mode_head,
  input  logic [ADDR_W-1:0]     deq_pc_head,
  output logic                  stall,
  output logic                  iss_valid,
  output logic [MICRO_W-1:0]    iss_opcode,
  output logic [REG_ADDR_W-1:0] iss_reg_addr_d,
  output logic [REG_ADDR_W-1:0] iss_reg_addr_s,
  output logic [REG_ADDR_W-1:0] iss_reg_addr_t,
  output logic [IMM_W-1:0]      iss_immediate,
  output logic [BIT_MODE_W-1:0] iss_bit_mode,
  output logic                  iss_efl_mode,
  output logic [ADDR_W-1:0]     iss_pc,
  input  logic                  exe_ready,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_reg_addr,
  input  logic                  wb_writes_d,
  input  logic                  wb_efl,
  input  logic                  flush
);

  issue_slot_t      head, slot_q, slot_d;
  logic             valid_q, valid_d;
  logic [NREGS-1:0] busy;
  logic             efl_busy, credit_ok;
  logic             live, head_wd, hazard, slot_free, can_issue, issue_fire;

  assign head = '{opcode: deq_opcode_head, rd: deq_reg_addr_d_head, rs: deq_reg_addr_s_head,
                  rt: deq_reg_addr_t_head, imm: deq_immediate_head, bit_mode: deq_bit_mode_head,
                  efl_mode: deq_efl_mode_head, pc: deq_pc_head};

  assign live      = (head.opcode != MICRO_NOP);
  assign head_wd   = writes_d(head.opcode);
  // Registered busy bits only: a writeback this cycle frees the source next cycle.
  assign hazard    = busy[head.rs] | busy[head.rt] | (head_wd & busy[head.rd])
                   | (head.efl_mode & efl_busy);
  assign slot_free = ~valid_q | exe_ready;
  assign can_issue = live & ~hazard & slot_free & credit_ok;
  assign issue_fire = can_issue & ~flush;
  assign stall     = live & ~can_issue & ~flush;

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (issue_fire) begin
      slot_d  = head;
      valid_d = 1'b1;
    end else if (valid_q && exe_ready) begin
      valid_d = 1'b0;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      slot_q  <= SLOT_RST;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  issue_scoreboard #(.INFLIGHT_MAX(INFLIGHT_MAX)) u_sb (
    .clk           (clk),
    .rstn          (rstn),
    .flush_i       (flush),
    .iss_fire_i    (issue_fire),
    .iss_writes_d_i(head_wd),
    .iss_efl_i     (head.efl_mode),
    .iss_rd_i      (head.rd),
    .wb_valid_i    (wb_valid),
    .wb_reg_addr_i (wb_reg_addr),
    .wb_writes_d_i (wb_writes_d),
    .wb_efl_i      (wb_efl),
    .busy_o        (busy),
    .efl_busy_o    (efl_busy),
    .credit_ok_o   (credit_ok)
  );

  assign iss_valid      = valid_q;
  assign iss_opcode     = slot_q.opcode;
  assign iss_reg_addr_d = slot_q.rd;
  assign iss_reg_addr_s = slot_q.rs;
  assign iss_reg_addr_t = slot_q.rt;
  assign iss_immediate  = slot_q.imm;
  assign iss_bit_mode   = slot_q.bit_mode;
  assign iss_efl_mode   = slot_q.efl_mode;
  assign iss_pc         = slot_q.pc;

endmodule

// File: tb/tb_micro_issue.sv
// tb/tb_micro_issue.sv - directed-vector bench for micro_issue
module tb_micro_issue;
  import micro_issue_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [MICRO_W-1:0]    deq_opcode_head;
  logic [REG_ADDR_W-1:0] deq_reg_addr_d_head, deq_reg_addr_s_head, deq_reg_addr_t_head;
  logic [IMM_W-1:0]      deq_immediate_head;
  logic [BIT_MODE_W-1:0] deq_bit_mode_head;
  logic                  deq_efl_mode_head;
  logic [ADDR_W-1:0]     deq_pc_head;
  logic                  stall, iss_valid;
  logic [MICRO_W-1:0]    iss_opcode;
  logic [REG_ADDR_W-1:0] iss_reg_addr_d, iss_reg_addr_s, iss_reg_addr_t;
  logic [IMM_W-1:0]      iss_immediate;
  logic [BIT_MODE_W-1:0] iss_bit_mode;
  logic                  iss_efl_mode;
  logic [ADDR_W-1:0]     iss_pc;
  logic                  exe_ready, wb_valid, wb_writes_d, wb_efl, flush;
  logic [REG_ADDR_W-1:0] wb_reg_addr;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  micro_issue #(.INFLIGHT_MAX(4)) dut (
    .clk(clk), .rstn(rstn),
    .deq_opcode_head(deq_opcode_head), .deq_reg_addr_d_head(deq_reg_addr_d_head),
    .deq_reg_addr_s_head(deq_reg_addr_s_head), .deq_reg_addr_t_head(deq_reg_addr_t_head),
    .deq_immediate_head(deq_immediate_head), .deq_bit_mode_head(deq_bit_mode_head),
    .deq_efl_mode_head(deq_efl_mode_head), .deq_pc_head(deq_pc_head),
    .stall(stall), .iss_valid(iss_valid), .iss_opcode(iss_opcode),
    .iss_reg_addr_d(iss_reg_addr_d), .iss_reg_addr_s(iss_reg_addr_s),
    .iss_reg_addr_t(iss_reg_addr_t), .iss_immediate(iss_immediate),
    .iss_bit_mode(iss_bit_mode), .iss_efl_mode(iss_efl_mode), .iss_pc(iss_pc),
    .exe_ready(exe_ready), .wb_valid(wb_valid), .wb_reg_addr(wb_reg_addr),
    .wb_writes_d(wb_writes_d), .wb_efl(wb_efl), .flush(flush)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled from then on.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic head(input logic [MICRO_W-1:0] op, input int d, input int s, input int t,
                      input logic efl);
    deq_opcode_head     = op;
    deq_reg_addr_d_head = REG_ADDR_W'(d);
    deq_reg_addr_s_head = REG_ADDR_W'(s);
    deq_reg_addr_t_head = REG_ADDR_W'(t);
    deq_immediate_head  = IMM_W'(16'hA000 + d);
    deq_bit_mode_head   = BIT_MODE_W'(d);
    deq_efl_mode_head   = efl;
    deq_pc_head         = ADDR_W'(32'h1000 + 4 * d);
  endtask

  task automatic wb(input int addr, input logic wd, input logic efl);
    wb_valid    = 1'b1;
    wb_reg_addr = REG_ADDR_W'(addr);
    wb_writes_d = wd;
    wb_efl      = efl;
    tick();
    wb_valid    = 1'b0;
    wb_writes_d = 1'b0;
    wb_efl      = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; exe_ready = 1'b1; flush = 1'b0;
    wb_valid = 1'b0; wb_reg_addr = '0; wb_writes_d = 1'b0; wb_efl = 1'b0;
    head(MICRO_NOP, 0, 0, 0, 1'b0);
    tick(); tick();
    chk("rst_valid", 64'(iss_valid), 64'd0);
    chk("rst_opcode", 64'(iss_opcode), 64'(MICRO_NOP));
    chk("rst_pc", 64'(iss_pc), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rstn = 1'b1;

    // Spurious writeback at zero in-flight must not wrap the credit count.
    wb(0, 1'b0, 1'b0);

    // Independent ops issue back to back.
    head(MICRO_ADD, 1, 2, 0, 1'b0); settle();
    chk("ind_stall0", 64'(stall), 64'd0);
    tick();
    chk("ind_valid0", 64'(iss_valid), 64'd1);
    chk("ind_d0", 64'(iss_reg_addr_d), 64'd1);
    chk("ind_pc0", 64'(iss_pc), 64'h1004);
    chk("ind_imm0", 64'(iss_immediate), 64'hA001);
    head(MICRO_ADD, 3, 4, 0, 1'b0); settle();
    chk("ind_stall1", 64'(stall), 64'd0);
    tick();
    chk("ind_valid1", 64'(iss_valid), 64'd1);
    chk("ind_d1", 64'(iss_reg_addr_d), 64'd3);
    chk("ind_s1", 64'(iss_reg_addr_s), 64'd4);
    head(MICRO_NOP, 0, 0, 0, 1'b0);
    tick();
    chk("ind_drain", 64'(iss_valid), 64'd0);
    wb(1, 1'b1, 1'b0);
    wb(3, 1'b1, 1'b0);

    // RAW on r1: held until the cycle after its writeback.
    head(MICRO_ADD, 1, 2, 0, 1'b0);
    tick();
    head(MICRO_ADD, 5, 1, 0, 1'b0); settle();
    chk("raw_stall0", 64'(stall), 64'd1);
    tick();
    chk("raw_stall1", 64'(stall), 64'd1);
    wb_valid = 1'b1; wb_reg_addr = 4'd1; wb_writes_d = 1'b1; settle();
    chk("raw_stall_wbcyc", 64'(stall), 64'd1);
    tick();
    wb_valid = 1'b0; wb_writes_d = 1'b0; settle();
    chk("raw_stall_after", 64'(stall), 64'd0);
    tick();
    chk("raw_issue_valid", 64'(iss_valid), 64'd1);
    chk("raw_issue_d", 64'(iss_reg_addr_d), 64'd5);
    head(MICRO_NOP, 0, 0, 0, 1'b0);
    tick();
    wb(5, 1'b1, 1'b0);

    // Backpressure: slot held stable while execute is not ready.
    exe_ready = 1'b0;
    head(MICRO_ADD, 6, 2, 0, 1'b0);
    tick();
    head(MICRO_ADD, 7, 3, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("bp_stall%0d", i), 64'(stall), 64'd1);
      chk($sformatf("bp_d%0d", i), 64'(iss_reg_addr_d), 64'd6);
      chk($sformatf("bp_valid%0d", i), 64'(iss_valid), 64'd1);
      tick();
    end
    chk("bp_pc_hold", 64'(iss_pc), 64'h1018);
    exe_ready = 1'b1; settle();
    chk("bp_release", 64'(stall), 64'd0);
    tick();
    chk("bp_resume_d", 64'(iss_reg_addr_d), 64'd7);
    head(MICRO_NOP, 0, 0, 0, 1'b0);
    tick();
    wb(6, 1'b1, 1'b0);
    wb(7, 1'b1, 1'b0);

    // Credit limit: four in flight, fifth waits for one writeback.
    for (int i = 0; i < 4; i++) begin
      head(MICRO_ADD, 8 + i, 2, 0, 1'b0); settle();
      chk($sformatf("cr_stall%0d", i), 64'(stall), 64'd0);
      tick();
    end
    head(MICRO_ADD, 12, 2, 0, 1'b0); settle();
    chk("cr_full_stall", 64'(stall), 64'd1);
    tick();
    chk("cr_full_stall2", 64'(stall), 64'd1);
    wb(8, 1'b1, 1'b0); settle();
    chk("cr_freed", 64'(stall), 64'd0);
    tick();
    chk("cr_fifth_d", 64'(iss_reg_addr_d), 64'd12);
    chk("cr_fifth_valid", 64'(iss_valid), 64'd1);
    head(MICRO_NOP, 0, 0, 0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("cr_flush_valid", 64'(iss_valid), 64'd0);

    // EFLAGS producer/consumer.
    head(MICRO_CMP, 0, 2, 3, 1'b1);
    tick();
    chk("efl_cmp_op", 64'(iss_opcode), 64'(MICRO_CMP));
    head(MICRO_JCC, 0, 0, 0, 1'b1); settle();
    chk("efl_stall0", 64'(stall), 64'd1);
    tick();
    chk("efl_stall1", 64'(stall), 64'd1);
    wb(0, 1'b0, 1'b1); settle();
    chk("efl_release", 64'(stall), 64'd0);
    tick();
    chk("efl_jcc_op", 64'(iss_opcode), 64'(MICRO_JCC));
    chk("efl_jcc_mode", 64'(iss_efl_mode), 64'd1);

    // Flush clears busy r1 and the held slot.
    head(MICRO_NOP, 0, 0, 0, 1'b0);
    flush = 1'b1; tick(); flush = 1'b0;
    head(MICRO_ADD, 1, 2, 0, 1'b0);
    tick();
    exe_ready = 1'b0;
    head(MICRO_ADD, 4, 1, 0, 1'b0); settle();
    chk("fl_pre_stall", 64'(stall), 64'd1);
    flush = 1'b1; settle();
    chk("fl_cyc_stall", 64'(stall), 64'd0);
    tick();
    flush = 1'b0; settle();
    chk("fl_valid", 64'(iss_valid), 64'd0);
    chk("fl_no_stall", 64'(stall), 64'd0);
    tick();
    chk("fl_issue_valid", 64'(iss_valid), 64'd1);
    chk("fl_issue_d", 64'(iss_reg_addr_d), 64'd4);

    // NOP head never stalls, then reset drops the un-accepted slot.
    head(MICRO_NOP, 0, 0, 0, 1'b0); settle();
    chk("nop_stall", 64'(stall), 64'd0);
    tick();
    chk("nop_hold_valid", 64'(iss_valid), 64'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mid_rst_valid", 64'(iss_valid), 64'd0);
    chk("mid_rst_op", 64'(iss_opcode), 64'(MICRO_NOP));
    exe_ready = 1'b1;
    head(MICRO_ADD, 2, 1, 4, 1'b0); settle();
    chk("mid_rst_clean", 64'(stall), 64'd0);
    tick();
    chk("mid_rst_issue", 64'(iss_reg_addr_d), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
